// File: rtl/experiment_cmd_scheduler_if.sv
// Bundles the shared experiment command port: two requesters, the response channel,
// the experiment side and the status outputs.
interface experiment_cmd_scheduler_if #(
    parameter int unsigned DATA_WIDTH = 32
);
    logic                  req0_valid;
    logic                  req0_ready;
    logic [DATA_WIDTH-1:0] req0_command;
    logic [DATA_WIDTH-1:0] req0_data;
    logic                  req1_valid;
    logic                  req1_ready;
    logic [DATA_WIDTH-1:0] req1_command;
    logic [DATA_WIDTH-1:0] req1_data;
    logic                  rsp_valid;
    logic                  rsp_ready;
    logic                  rsp_id;
    logic [DATA_WIDTH-1:0] rsp_data;
    logic                  exp_commit;
    logic [DATA_WIDTH-1:0] exp_command;
    logic [DATA_WIDTH-1:0] exp_data_out;
    logic [DATA_WIDTH-1:0] exp_data_in;
    logic                  busy;
    logic [15:0]           done_count;

    modport master (
        output req0_valid, req0_command, req0_data,
        output req1_valid, req1_command, req1_data,
        output rsp_ready, exp_data_in,
        input  req0_ready, req1_ready,
        input  rsp_valid, rsp_id, rsp_data,
        input  exp_commit, exp_command, exp_data_out,
        input  busy, done_count
    );

    modport slave (
        input  req0_valid, req0_command, req0_data,
        input  req1_valid, req1_command, req1_data,
        input  rsp_ready, exp_data_in,
        output req0_ready, req1_ready,
        output rsp_valid, rsp_id, rsp_data,
        output exp_commit, exp_command, exp_data_out,
        output busy, done_count
    );
endinterface

// File: rtl/experiment_cmd_scheduler.sv
// Round-robin scheduler sharing the experiment command port between the host and the
// sweep source: one commit per accepted command, result sampled after a settle interval.
module experiment_cmd_scheduler #(
    parameter int unsigned DATA_WIDTH    = 32,
    parameter int unsigned SETTLE_CYCLES = 4,
    parameter int unsigned CNT_WIDTH     = 8
) (
    input logic                   S_AXI_ACLK,
    input logic                   S_AXI_ARESETN,
    experiment_cmd_scheduler_if.slave bus
);

    localparam int unsigned DONE_WIDTH = 16;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } state_t;

    state_t                  state_q;
    logic                    last_grant_q;
    logic [CNT_WIDTH-1:0]    settle_cnt_q;
    logic [DATA_WIDTH-1:0]   exp_command_q;
    logic [DATA_WIDTH-1:0]   exp_data_out_q;
    logic [DATA_WIDTH-1:0]   rsp_data_q;
    logic                    exp_commit_q;
    logic                    rsp_valid_q;
    logic                    rsp_id_q;
    logic                    busy_q;
    logic [DONE_WIDTH-1:0]   done_cnt_q;

    logic grant_c;
    logic grant_id_c;

    // Under contention the requester not served last wins; a lone requester always wins.
    always_comb begin
        grant_c    = (state_q == IDLE) && (bus.req0_valid || bus.req1_valid);
        grant_id_c = (bus.req0_valid && bus.req1_valid) ? ~last_grant_q : bus.req1_valid;
    end

    assign bus.req0_ready = grant_c && !grant_id_c;
    assign bus.req1_ready = grant_c &&  grant_id_c;

    always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
        if (!S_AXI_ARESETN) begin
            state_q        <= IDLE;
            last_grant_q   <= 1'b1;
            settle_cnt_q   <= '0;
            exp_command_q  <= '0;
            exp_data_out_q <= '0;
            rsp_data_q     <= '0;
            exp_commit_q   <= 1'b0;
            rsp_valid_q    <= 1'b0;
            rsp_id_q       <= 1'b0;
            busy_q         <= 1'b0;
            done_cnt_q     <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (grant_c) begin
                        exp_command_q  <= grant_id_c ? bus.req1_command : bus.req0_command;
                        exp_data_out_q <= grant_id_c ? bus.req1_data    : bus.req0_data;
                        rsp_id_q       <= grant_id_c;
                        last_grant_q   <= grant_id_c;
                        exp_commit_q   <= 1'b1;
                        busy_q         <= 1'b1;
                        state_q        <= ISSUE;
                    end
                end
                ISSUE: begin
                    exp_commit_q <= 1'b0;
                    settle_cnt_q <= CNT_WIDTH'(SETTLE_CYCLES);
                    state_q      <= WAIT;
                end
                WAIT: begin
                    settle_cnt_q <= settle_cnt_q - CNT_WIDTH'(1);
                    if (settle_cnt_q == CNT_WIDTH'(1)) begin
                        rsp_data_q  <= bus.exp_data_in;
                        rsp_valid_q <= 1'b1;
                        state_q     <= RESP;
                    end
                end
                RESP: begin
                    if (bus.rsp_ready) begin
                        rsp_valid_q <= 1'b0;
                        busy_q      <= 1'b0;
                        done_cnt_q  <= done_cnt_q + DONE_WIDTH'(1);
                        state_q     <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.exp_commit   = exp_commit_q;
    assign bus.exp_command  = exp_command_q;
    assign bus.exp_data_out = exp_data_out_q;
    assign bus.rsp_valid    = rsp_valid_q;
    assign bus.rsp_id       = rsp_id_q;
    assign bus.rsp_data     = rsp_data_q;
    assign bus.busy         = busy_q;
    assign bus.done_count   = done_cnt_q;

endmodule

// File: tb/tb_experiment_cmd_scheduler.sv
// Self-checking bench for experiment_cmd_scheduler: directed scenarios plus randomized
// traffic checked against a transaction-level model of arbitration, latency and counting.
module tb_experiment_cmd_scheduler;

    localparam int unsigned DW = 32;
    localparam int S4 = 4;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   cyc = 0;
    int   checks = 0;
    int   failures = 0;

    logic        model_last;
    logic [15:0] exp_done;

    experiment_cmd_scheduler_if #(.DATA_WIDTH(DW)) b ();
    experiment_cmd_scheduler_if #(.DATA_WIDTH(DW)) b1 ();

    experiment_cmd_scheduler #(.DATA_WIDTH(DW), .SETTLE_CYCLES(S4), .CNT_WIDTH(8)) dut (
        .S_AXI_ACLK(clk), .S_AXI_ARESETN(rst_n), .bus(b.slave)
    );

    experiment_cmd_scheduler #(.DATA_WIDTH(DW), .SETTLE_CYCLES(1), .CNT_WIDTH(8)) dut1 (
        .S_AXI_ACLK(clk), .S_AXI_ARESETN(rst_n), .bus(b1.slave)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #2000000;
        $display("FAIL watchdog time limit expired");
        $fatal(1, "watchdog");
    end

    task automatic reset_dut();
        rst_n = 1'b0;
        b.req0_valid = 1'b0; b.req1_valid = 1'b0; b.rsp_ready = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        model_last = 1'b1;
        exp_done   = 16'd0;
    endtask

    // One command through the full accept/commit/settle/response sequence.
    task automatic issue(input logic v0, input logic v1,
                         input logic [DW-1:0] c0, input logic [DW-1:0] d0,
                         input logic [DW-1:0] c1, input logic [DW-1:0] d1,
                         input logic [DW-1:0] res, input int hold, input bit keep,
                         output logic g, output int acc);
        logic [DW-1:0] ecmd, edat;
        b.req0_valid = v0; b.req1_valid = v1;
        b.req0_command = c0; b.req0_data = d0;
        b.req1_command = c1; b.req1_data = d1;
        b.rsp_ready = (hold == 0);
        #1;
        g = (v0 && v1) ? ~model_last : v1;
        checks++;
        if (b.req0_ready !== ~g || b.req1_ready !== g) begin
            failures++;
            $display("FAIL grant_ready got r0=%b r1=%b expected r0=%b r1=%b", b.req0_ready, b.req1_ready, ~g, g);
        end
        checks++;
        if (b.busy !== 1'b0 || b.exp_commit !== 1'b0) begin
            failures++;
            $display("FAIL idle_outputs got busy=%b commit=%b expected 0 0", b.busy, b.exp_commit);
        end
        acc = cyc;
        model_last = g;
        ecmd = g ? c1 : c0;
        edat = g ? d1 : d0;
        @(negedge clk);
        if (!keep) begin b.req0_valid = 1'b0; b.req1_valid = 1'b0; end
        b.exp_data_in = res;
        checks++;
        if (b.exp_commit !== 1'b1 || b.exp_command !== ecmd || b.exp_data_out !== edat || b.rsp_id !== g || b.busy !== 1'b1) begin
            failures++;
            $display("FAIL issue_cycle got commit=%b cmd=%h data=%h id=%b busy=%b expected 1 %h %h %b 1",
                     b.exp_commit, b.exp_command, b.exp_data_out, b.rsp_id, b.busy, ecmd, edat, g);
        end
        for (int i = 0; i < S4; i++) begin
            @(negedge clk);
            checks++;
            if (b.exp_commit !== 1'b0 || b.rsp_valid !== 1'b0 || b.req0_ready !== 1'b0 || b.req1_ready !== 1'b0 ||
                b.exp_command !== ecmd || b.rsp_id !== g) begin
                failures++;
                $display("FAIL wait_cycle%0d got commit=%b rsp_valid=%b r0=%b r1=%b cmd=%h id=%b expected 0 0 0 0 %h %b",
                         i, b.exp_commit, b.rsp_valid, b.req0_ready, b.req1_ready, b.exp_command, b.rsp_id, ecmd, g);
            end
        end
        @(negedge clk);
        checks++;
        if (b.rsp_valid !== 1'b1 || b.rsp_data !== res || b.rsp_id !== g || b.exp_commit !== 1'b0 ||
            b.req0_ready !== 1'b0 || b.req1_ready !== 1'b0) begin
            failures++;
            $display("FAIL response got valid=%b data=%h id=%b commit=%b r0=%b r1=%b expected 1 %h %b 0 0 0",
                     b.rsp_valid, b.rsp_data, b.rsp_id, b.exp_commit, b.req0_ready, b.req1_ready, res, g);
        end
        for (int i = 0; i < hold; i++) begin
            b.exp_data_in = $urandom;
            @(negedge clk);
            checks++;
            if (b.rsp_valid !== 1'b1 || b.rsp_data !== res || b.exp_commit !== 1'b0 ||
                b.req0_ready !== 1'b0 || b.req1_ready !== 1'b0) begin
                failures++;
                $display("FAIL backpressure_hold%0d got valid=%b data=%h commit=%b r0=%b r1=%b expected 1 %h 0 0 0",
                         i, b.rsp_valid, b.rsp_data, b.exp_commit, b.req0_ready, b.req1_ready, res);
            end
        end
        b.rsp_ready = 1'b1;
        exp_done = exp_done + 16'd1;
        @(negedge clk);
        b.rsp_ready = 1'b0;
        checks++;
        if (b.rsp_valid !== 1'b0 || b.busy !== 1'b0 || b.done_count !== exp_done) begin
            failures++;
            $display("FAIL after_handshake got valid=%b busy=%b done=%h expected 0 0 %h",
                     b.rsp_valid, b.busy, b.done_count, exp_done);
        end
    endtask

    task automatic test_reset();
        b.req0_valid = 1'b0; b.req1_valid = 1'b0; b.rsp_ready = 1'b0;
        b.req0_command = '0; b.req0_data = '0; b.req1_command = '0; b.req1_data = '0;
        b.exp_data_in = '0;
        b1.req0_valid = 1'b0; b1.req1_valid = 1'b0; b1.rsp_ready = 1'b0;
        b1.req0_command = '0; b1.req0_data = '0; b1.req1_command = '0; b1.req1_data = '0;
        b1.exp_data_in = '0;
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if (b.exp_commit !== 1'b0 || b.exp_command !== '0 || b.exp_data_out !== '0 || b.busy !== 1'b0) begin
            failures++;
            $display("FAIL reset_exp got commit=%b cmd=%h data=%h busy=%b expected all 0",
                     b.exp_commit, b.exp_command, b.exp_data_out, b.busy);
        end
        checks++;
        if (b.rsp_valid !== 1'b0 || b.rsp_id !== 1'b0 || b.rsp_data !== '0 || b.done_count !== 16'd0) begin
            failures++;
            $display("FAIL reset_rsp got valid=%b id=%b data=%h done=%h expected all 0",
                     b.rsp_valid, b.rsp_id, b.rsp_data, b.done_count);
        end
        rst_n = 1'b1;
        model_last = 1'b1;
        exp_done = 16'd0;
        @(negedge clk);
    endtask

    task automatic test_single();
        logic g; int acc;
        issue(1'b1, 1'b0, 32'h0000_0011, 32'hA5A5_A5A5, '0, '0, 32'h1234_5678, 0, 1'b0, g, acc);
        checks++;
        if (b.done_count !== 16'd1) begin
            failures++;
            $display("FAIL single_done got %h expected 0001", b.done_count);
        end
    endtask

    task automatic test_contention();
        logic g; int acc; int prev;
        logic [3:0] want;
        want = 4'b1010;
        reset_dut();
        prev = 0;
        for (int i = 0; i < 4; i++) begin
            issue(1'b1, 1'b1, $urandom, $urandom, $urandom, $urandom, $urandom, 0, 1'b1, g, acc);
            checks++;
            if (g !== want[i] || b.rsp_id !== want[i]) begin
                failures++;
                $display("FAIL contention_order%0d got grant=%b id=%b expected %b", i, g, b.rsp_id, want[i]);
            end
            if (i > 0) begin
                checks++;
                if (acc - prev !== 7) begin
                    failures++;
                    $display("FAIL contention_spacing%0d got %0d expected 7", i, acc - prev);
                end
            end
            prev = acc;
        end
        b.req0_valid = 1'b0; b.req1_valid = 1'b0;
    endtask

    task automatic test_backpressure();
        logic g; int acc;
        issue(1'b0, 1'b1, $urandom, $urandom, $urandom, $urandom, 32'hDEAD_BEEF, 10, 1'b1, g, acc);
        b.req0_valid = 1'b0; b.req1_valid = 1'b0;
    endtask

    task automatic test_random();
        logic g; int acc; logic [1:0] v; int hold; bit keep;
        for (int i = 0; i < 12; i++) begin
            v = 2'($urandom_range(1, 3));
            hold = $urandom_range(0, 3);
            keep = 1'($urandom_range(0, 1));
            issue(v[0], v[1], $urandom, $urandom, $urandom, $urandom, $urandom, hold, keep, g, acc);
        end
        b.req0_valid = 1'b0; b.req1_valid = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_reset_during_wait();
        logic g; int acc;
        b.req0_valid = 1'b1; b.req0_command = $urandom; b.req0_data = $urandom;
        @(negedge clk);
        b.req0_valid = 1'b0;
        b.exp_data_in = $urandom;
        @(negedge clk);
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if (b.exp_commit !== 1'b0 || b.exp_command !== '0 || b.exp_data_out !== '0 || b.busy !== 1'b0 ||
            b.rsp_valid !== 1'b0 || b.rsp_id !== 1'b0 || b.rsp_data !== '0 || b.done_count !== 16'd0) begin
            failures++;
            $display("FAIL reset_mid_wait got commit=%b cmd=%h data=%h busy=%b valid=%b id=%b rdata=%h done=%h expected all 0",
                     b.exp_commit, b.exp_command, b.exp_data_out, b.busy, b.rsp_valid, b.rsp_id, b.rsp_data, b.done_count);
        end
        @(negedge clk);
        rst_n = 1'b1;
        model_last = 1'b1;
        exp_done = 16'd0;
        b.req0_valid = 1'b1;
        @(negedge clk);
        b.req0_valid = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if (b.exp_commit !== 1'b0 || b.busy !== 1'b0) begin
            failures++;
            $display("FAIL reset_mid_issue got commit=%b busy=%b expected 0 0", b.exp_commit, b.busy);
        end
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checks++;
            if (b.exp_commit !== 1'b0 || b.busy !== 1'b0 || b.rsp_valid !== 1'b0) begin
                failures++;
                $display("FAIL post_reset_idle%0d got commit=%b busy=%b valid=%b expected 0 0 0",
                         i, b.exp_commit, b.busy, b.rsp_valid);
            end
        end
        issue(1'b0, 1'b1, $urandom, $urandom, $urandom, $urandom, $urandom, 1, 1'b0, g, acc);
        checks++;
        if (g !== 1'b1 || b.done_count !== 16'd1) begin
            failures++;
            $display("FAIL post_reset_cmd got grant=%b done=%h expected 1 0001", g, b.done_count);
        end
    endtask

    task automatic test_counter_wrap();
        logic g; int acc;
        force dut.done_cnt_q = 16'hFFFF;
        @(negedge clk);
        release dut.done_cnt_q;
        exp_done = 16'hFFFF;
        @(negedge clk);
        checks++;
        if (b.done_count !== 16'hFFFF) begin
            failures++;
            $display("FAIL wrap_preset got %h expected ffff", b.done_count);
        end
        issue(1'b1, 1'b1, $urandom, $urandom, $urandom, $urandom, $urandom, 0, 1'b0, g, acc);
        checks++;
        if (b.done_count !== 16'h0000) begin
            failures++;
            $display("FAIL wrap_result got %h expected 0000", b.done_count);
        end
    endtask

    task automatic test_min_settle();
        logic [DW-1:0] cmd, early, res;
        cmd = $urandom; early = 32'h1111_1111; res = 32'h5A5A_0001;
        b1.req1_valid = 1'b1; b1.req1_command = cmd; b1.req1_data = ~cmd;
        #1;
        checks++;
        if (b1.req1_ready !== 1'b1 || b1.req0_ready !== 1'b0) begin
            failures++;
            $display("FAIL min_accept got r0=%b r1=%b expected 0 1", b1.req0_ready, b1.req1_ready);
        end
        @(negedge clk);
        b1.req1_valid = 1'b0;
        b1.exp_data_in = early;
        checks++;
        if (b1.exp_commit !== 1'b1 || b1.exp_command !== cmd || b1.exp_data_out !== ~cmd || b1.rsp_id !== 1'b1) begin
            failures++;
            $display("FAIL min_commit got commit=%b cmd=%h data=%h id=%b expected 1 %h %h 1",
                     b1.exp_commit, b1.exp_command, b1.exp_data_out, b1.rsp_id, cmd, ~cmd);
        end
        @(negedge clk);
        b1.exp_data_in = res;
        checks++;
        if (b1.rsp_valid !== 1'b0 || b1.exp_commit !== 1'b0) begin
            failures++;
            $display("FAIL min_wait got valid=%b commit=%b expected 0 0", b1.rsp_valid, b1.exp_commit);
        end
        @(negedge clk);
        b1.exp_data_in = 32'hFFFF_0000;
        checks++;
        if (b1.rsp_valid !== 1'b1 || b1.rsp_data !== res || b1.rsp_id !== 1'b1) begin
            failures++;
            $display("FAIL min_response got valid=%b data=%h id=%b expected 1 %h 1",
                     b1.rsp_valid, b1.rsp_data, b1.rsp_id, res);
        end
        b1.rsp_ready = 1'b1;
        @(negedge clk);
        b1.rsp_ready = 1'b0;
        checks++;
        if (b1.rsp_valid !== 1'b0 || b1.busy !== 1'b0 || b1.done_count !== 16'd1) begin
            failures++;
            $display("FAIL min_done got valid=%b busy=%b done=%h expected 0 0 0001",
                     b1.rsp_valid, b1.busy, b1.done_count);
        end
    endtask

    initial begin
        model_last = 1'b1;
        exp_done = 16'd0;
        @(negedge clk);
        test_reset();
        test_single();
        test_contention();
        test_backpressure();
        test_random();
        test_reset_during_wait();
        test_counter_wrap();
        test_min_settle();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
